// File: rtl/fractal_pkg.sv
// fractal_pkg: shared definitions for the fractal frame-buffer fill controller.
//   - Q_FRAC        : fraction bits of the Q.16 coordinate format
//   - ST_*          : scan FSM state encoding (fsm_state_t)
//   - quantise()    : iteration count -> stored pixel code
//   - palette()     : 16-entry 24-bit colour LUT, used when FRACTAL_FB_PALETTE_EN is defined
package fractal_pkg;

  localparam int Q_FRAC = 16;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_ISSUE = 2'd0;
  localparam fsm_state_t ST_WAIT  = 2'd1;
  localparam fsm_state_t ST_WRITE = 2'd2;
  localparam fsm_state_t ST_DONE  = 2'd3;

  // Clamp to max_iter-1 so a count of exactly max_iter lands on all-ones,
  // then keep the top pix_w bits of the log2(max_iter)-bit range.
  function automatic logic [31:0] quantise(input logic [31:0] iter,
                                           input int max_log2, input int pix_w);
    logic [31:0] lim;
    logic [31:0] sat;
    lim = (32'd1 << max_log2) - 32'd1;
    sat = (iter > lim) ? lim : iter;
    return sat >> (max_log2 - pix_w);
  endfunction

  function automatic logic [23:0] palette(input logic [3:0] idx);
    logic [23:0] c;
    case (idx)
      4'd0:    c = 24'h000000;
      4'd1:    c = 24'h19071a;
      4'd2:    c = 24'h09012f;
      4'd3:    c = 24'h040449;
      4'd4:    c = 24'h000764;
      4'd5:    c = 24'h0c2c8a;
      4'd6:    c = 24'h1852b1;
      4'd7:    c = 24'h397dd1;
      4'd8:    c = 24'h86b5e5;
      4'd9:    c = 24'hd3ecf8;
      4'd10:   c = 24'hf1e9bf;
      4'd11:   c = 24'hf8c95f;
      4'd12:   c = 24'hffaa00;
      4'd13:   c = 24'hcc8000;
      4'd14:   c = 24'h995700;
      default: c = 24'h6a3403;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fractal_fb_view.sv
// fractal_fb_view: view state (zoom level, centre, pixel pitch) for the fill scan.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   zoom_in_i, zoom_out_i single-cycle zoom pulses (both together = no-op)
//   pan_i[3:0]            {up, down, left, right} pan pulses
//   param_next_i          Julia-constant advance (forces a redraw)
//   step_o                current pixel pitch, STEP0 >> zoom
//   row_x0_o, row_y0_o    coordinate of screen pixel (0,0) for the current view
//   view_changed_o        combinational: this cycle's pulses change the picture
module fractal_fb_view #(
  parameter int H_RES       = 1280,
  parameter int V_RES       = 720,
  parameter int COORD_W     = 32,
  parameter int ZOOM_LEVELS = 4,
  parameter int STEP0       = 410,
  parameter int PAN_PIX     = 64,
  parameter int CX0         = 0,
  parameter int CY0         = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      zoom_in_i,
  input  logic                      zoom_out_i,
  input  logic [3:0]                pan_i,
  input  logic                      param_next_i,
  output logic signed [COORD_W-1:0] step_o,
  output logic signed [COORD_W-1:0] row_x0_o,
  output logic signed [COORD_W-1:0] row_y0_o,
  output logic                      view_changed_o
);
  import fractal_pkg::*;

  localparam int ZW = (ZOOM_LEVELS > 1) ? $clog2(ZOOM_LEVELS) : 1;
  localparam logic [ZW-1:0] ZMAX = ZW'(ZOOM_LEVELS - 1);
  localparam logic signed [COORD_W-1:0] STEP0_C = COORD_W'(STEP0);
  localparam logic signed [COORD_W-1:0] HALF_H  = COORD_W'(H_RES / 2);
  localparam logic signed [COORD_W-1:0] HALF_V  = COORD_W'(V_RES / 2);
  localparam logic signed [COORD_W-1:0] PAN_C   = COORD_W'(PAN_PIX);

  logic [ZW-1:0]             zoom_q, zoom_d;
  logic signed [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic signed [COORD_W-1:0] pan_amt;
  logic                      zoom_chg, pan_chg;

  assign step_o   = STEP0_C >>> zoom_q;
  assign pan_amt  = PAN_C * step_o;
  assign row_x0_o = cx_q - HALF_H * step_o;
  assign row_y0_o = cy_q + HALF_V * step_o;

  always_comb begin
    zoom_d   = zoom_q;
    zoom_chg = 1'b0;
    if (zoom_in_i && !zoom_out_i && zoom_q != ZMAX) begin
      zoom_d   = zoom_q + ZW'(1);
      zoom_chg = 1'b1;
    end else if (zoom_out_i && !zoom_in_i && zoom_q != '0) begin
      zoom_d   = zoom_q - ZW'(1);
      zoom_chg = 1'b1;
    end
    // Opposing bits cancel; pan uses the pitch in force before any zoom this cycle.
    cx_d = cx_q;
    cy_d = cy_q;
    if (pan_i[0] && !pan_i[1]) cx_d = cx_q + pan_amt;
    if (pan_i[1] && !pan_i[0]) cx_d = cx_q - pan_amt;
    if (pan_i[3] && !pan_i[2]) cy_d = cy_q + pan_amt;
    if (pan_i[2] && !pan_i[3]) cy_d = cy_q - pan_amt;
    pan_chg        = (pan_i[0] ^ pan_i[1]) | (pan_i[2] ^ pan_i[3]);
    view_changed_o = zoom_chg | pan_chg | param_next_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zoom_q <= '0;
      cx_q   <= COORD_W'(CX0);
      cy_q   <= COORD_W'(CY0);
    end else begin
      zoom_q <= zoom_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
    end
  end

endmodule

// File: rtl/fractal_fb_ctrl.sv
// fractal_fb_ctrl: frame-buffer fill controller for the fractal HDMI pipeline.
// Scans every pixel, requests an iteration count from the fractal core,
// quantises it and writes it to the pixel BRAM; also drives the display read side.
// Build option: define FRACTAL_FB_PALETTE_EN for colour-LUT output, else greyscale.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   zoom_in_i, zoom_out_i, pan_i     view controls; param_next_i advances the Julia constant
//   core_c_change_o                  registered copy of param_next_i
//   req_valid_o/req_ready_i          coordinate request handshake, req_x_o/req_y_o in Q.16
//   resp_valid_i, resp_iter_i        single-cycle iteration result
//   wr_en_o, wr_addr_o, wr_data_o    BRAM port A write
//   sx_i, sy_i                       display scan position
//   rd_addr_o, rd_data_i             BRAM port B (one-cycle read latency)
//   red_o, green_o, blue_o           pixel colour, two cycles after sx_i/sy_i
//   frame_done_o                     pulse the cycle after the last write
module fractal_fb_ctrl #(
  parameter int H_RES       = 1280,
  parameter int V_RES       = 720,
  parameter int ADDR_W      = 20,
  parameter int PIX_W       = 4,
  parameter int ITER_W      = 9,
  parameter int MAX_ITER    = 256,
  parameter int COORD_W     = 32,
  parameter int ZOOM_LEVELS = 4,
  parameter int STEP0       = 410,
  parameter int PAN_PIX     = 64,
  parameter int CX0         = 0,
  parameter int CY0         = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      zoom_in_i,
  input  logic                      zoom_out_i,
  input  logic [3:0]                pan_i,
  input  logic                      param_next_i,
  output logic                      core_c_change_o,
  output logic                      req_valid_o,
  input  logic                      req_ready_i,
  output logic signed [COORD_W-1:0] req_x_o,
  output logic signed [COORD_W-1:0] req_y_o,
  input  logic                      resp_valid_i,
  input  logic [ITER_W-1:0]         resp_iter_i,
  output logic                      wr_en_o,
  output logic [ADDR_W-1:0]         wr_addr_o,
  output logic [PIX_W-1:0]          wr_data_o,
  input  logic [15:0]               sx_i,
  input  logic [15:0]               sy_i,
  output logic [ADDR_W-1:0]         rd_addr_o,
  input  logic [PIX_W-1:0]          rd_data_i,
  output logic [7:0]                red_o,
  output logic [7:0]                green_o,
  output logic [7:0]                blue_o,
  output logic                      frame_done_o
);
  import fractal_pkg::*;

  localparam int LOG2_MAX  = $clog2(MAX_ITER);
  localparam int RD_STAGES = 2;
  localparam logic signed [COORD_W-1:0] STEP0_C  = COORD_W'(STEP0);
  localparam logic signed [COORD_W-1:0] X_START0 = COORD_W'(CX0) - COORD_W'(H_RES / 2) * STEP0_C;
  localparam logic signed [COORD_W-1:0] Y_START0 = COORD_W'(CY0) + COORD_W'(V_RES / 2) * STEP0_C;

  logic signed [COORD_W-1:0] step, row_x0, row_y0;
  logic                      view_chg;

  fractal_fb_view #(
    .H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W), .ZOOM_LEVELS(ZOOM_LEVELS),
    .STEP0(STEP0), .PAN_PIX(PAN_PIX), .CX0(CX0), .CY0(CY0)
  ) u_view (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .zoom_in_i      (zoom_in_i),
    .zoom_out_i     (zoom_out_i),
    .pan_i          (pan_i),
    .param_next_i   (param_next_i),
    .step_o         (step),
    .row_x0_o       (row_x0),
    .row_y0_o       (row_y0),
    .view_changed_o (view_chg)
  );

  // ---------------- fill scan ----------------
  fsm_state_t                state_q, state_d;
  logic [15:0]               x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic signed [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [PIX_W-1:0]          code_q, code_d;
  logic                      pend_q, pend_d;
  logic                      req_valid_q, done_q, done_d, c_chg_q;
  logic                      last_pix;

  assign last_pix = (x_q == 16'(H_RES - 1)) && (y_q == 16'(V_RES - 1));

  // pend_q is set the cycle after a view change, by which point the view
  // registers already hold the new view, so the (0,0) restart coordinates
  // are always taken from pend_q rather than from the raw change pulse.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    code_d  = code_q;
    pend_d  = pend_q | view_chg;
    done_d  = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (req_valid_q && req_ready_i) begin
          state_d = ST_WAIT;
        end else if (pend_q) begin
          x_d    = '0;
          y_d    = '0;
          addr_d = '0;
          cx_d   = row_x0;
          cy_d   = row_y0;
          pend_d = view_chg;
        end
      end
      ST_WAIT: begin
        if (resp_valid_i) begin
          if (pend_q || view_chg) begin
            state_d = ST_ISSUE;      // response consumed, restart from ISSUE
          end else begin
            code_d  = PIX_W'(quantise(32'(resp_iter_i), LOG2_MAX, PIX_W));
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (pend_q || view_chg) begin
          state_d = ST_ISSUE;
        end else if (last_pix) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ISSUE;
          addr_d  = addr_q + ADDR_W'(1);
          if (x_q == 16'(H_RES - 1)) begin
            x_d  = '0;
            y_d  = y_q + 16'd1;
            cx_d = row_x0;
            cy_d = cy_q - step;      // y counts down so the image is upright
          end else begin
            x_d  = x_q + 16'd1;
            cx_d = cx_q + step;
          end
        end
      end
      default: begin
        if (pend_q) begin
          state_d = ST_ISSUE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          cx_d    = row_x0;
          cy_d    = row_y0;
          pend_d  = view_chg;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_ISSUE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      cx_q        <= X_START0;
      cy_q        <= Y_START0;
      code_q      <= '0;
      pend_q      <= 1'b0;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
      c_chg_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      code_q      <= code_d;
      pend_q      <= pend_d;
      // Registered so a pending restart drops the request the cycle after the change.
      req_valid_q <= (state_d == ST_ISSUE) && !pend_d;
      done_q      <= done_d;
      c_chg_q     <= param_next_i;
    end
  end

  assign req_valid_o     = req_valid_q;
  assign req_x_o         = cx_q;
  assign req_y_o         = cy_q;
  assign wr_en_o         = (state_q == ST_WRITE);
  assign wr_addr_o       = addr_q;
  assign wr_data_o       = code_q;
  assign frame_done_o    = done_q;
  assign core_c_change_o = c_chg_q;

  // ---------------- display read path ----------------
  logic [ADDR_W-1:0]      rd_addr_q;
  logic [RD_STAGES:1]     vld_pipe_q;
  logic                   in_range;
  logic [23:0]            rgb_w;

  assign in_range = (32'(sx_i) < H_RES) && (32'(sy_i) < V_RES);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_addr_q  <= '0;
      vld_pipe_q <= '0;
    end else begin
      rd_addr_q  <= ADDR_W'(sy_i) * ADDR_W'(H_RES) + ADDR_W'(sx_i);
      vld_pipe_q <= {vld_pipe_q[RD_STAGES-1:1], in_range};
    end
  end

  assign rd_addr_o = rd_addr_q;

`ifdef FRACTAL_FB_PALETTE_EN
  // Rescale the code to the 16-entry LUT index.
  assign rgb_w = palette(4'((32'(rd_data_i) << 4) >> PIX_W));
`else
  // Repeat the code bit pattern across the byte (PIX_W=4: code*17).
  function automatic logic [7:0] grey(input logic [PIX_W-1:0] c);
    logic [7:0] g;
    for (int i = 0; i < 8; i++) g[7-i] = c[PIX_W-1-(i % PIX_W)];
    return g;
  endfunction
  assign rgb_w = {3{grey(rd_data_i)}};
`endif

  // rd_data_i is the BRAM's registered output, so colour decode is the last
  // stage; the in-range flag travels two stages to line up with it.
  assign {red_o, green_o, blue_o} = vld_pipe_q[RD_STAGES] ? rgb_w : 24'h0;

endmodule

// File: tb/tb_fractal_fb_ctrl.sv
`timescale 1ns/1ps
module tb_fractal_fb_ctrl;
  localparam int H = 8, V = 4, CW = 32, AW = 20, PW = 4, IW = 9;
  localparam int STEP0 = 410, PAN = 64, NPIX = H * V;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 zoom_in, zoom_out, param_next, req_ready, resp_valid;
  logic [3:0]           pan;
  logic [IW-1:0]        resp_iter;
  logic [15:0]          sx, sy;
  logic [PW-1:0]        rd_data;
  logic                 core_c_change, req_valid, wr_en, frame_done;
  logic signed [CW-1:0] req_x, req_y;
  logic [AW-1:0]        wr_addr, rd_addr;
  logic [PW-1:0]        wr_data;
  logic [7:0]           red, green, blue;

  always #5 clk = ~clk;

  fractal_fb_ctrl #(.H_RES(H), .V_RES(V)) dut (
    .clk_i(clk), .rst_i(rst), .zoom_in_i(zoom_in), .zoom_out_i(zoom_out),
    .pan_i(pan), .param_next_i(param_next), .core_c_change_o(core_c_change),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .req_x_o(req_x), .req_y_o(req_y),
    .resp_valid_i(resp_valid), .resp_iter_i(resp_iter),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .sx_i(sx), .sy_i(sy), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .red_o(red), .green_o(green), .blue_o(blue), .frame_done_o(frame_done)
  );

  // BRAM port B model: one-cycle registered read of a fixed pattern
  always @(posedge clk) rd_data <= PW'(rd_addr ^ 20'h5);

  int n_checks = 0, n_errors = 0, fd_cnt = 0;
  int m_cx, m_cy, m_zoom;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // write scoreboard + frame_done counter
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) chk("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(wr_data), 32'(mon_e.data));
      end
    end
    if (!rst && frame_done) fd_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int qexp(input int it);
    int s;
    s = (it >= 256) ? 255 : it;
    return s >> 4;
  endfunction

  function automatic int iter_for(input int p, input int mode);
    if (mode == 1) begin
      case (p)
        0: return 256;
        1: return 255;
        2: return 16;
        3: return 15;
        default: ;
      endcase
    end
    return (p % H) + (p / H);
  endfunction

  // Core model: accept after two cycles of valid, answer one cycle later.
  task automatic serve_one(input int p, input int it, input bit drop_pan);
    int n, x, y, st;
    n = 0; x = p % H; y = p / H; st = STEP0 >> m_zoom;
    while (!req_valid && n < 100) begin tick(); n++; end
    chk("req_valid_seen", 32'(req_valid), 32'd1);
    if (!req_valid) return;
    chk("req_x", req_x, 32'(m_cx - (H / 2) * st + x * st));
    chk("req_y", req_y, 32'(m_cy + (V / 2) * st - y * st));
    tick(); tick();
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    if (drop_pan) begin
      pan = 4'b0001; tick(); pan = 4'b0000;
      m_cx = m_cx + PAN * st;
    end
    tick();
    resp_valid = 1'b1; resp_iter = IW'(it);
    if (!drop_pan) exp_q.push_back('{p, qexp(it)});
    tick();
    resp_valid = 1'b0;
    chk("wr_en_latency", 32'(wr_en), drop_pan ? 32'd0 : 32'd1);
  endtask

  task automatic serve_frame(input int start, input int mode);
    for (int p = start; p < NPIX; p++) serve_one(p, iter_for(p, mode), 1'b0);
    tick();
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    tick();
    chk("frame_done_clear", 32'(frame_done), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_valid"}, 32'(req_valid), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_c_change"}, 32'(core_c_change), 32'd0);
    chk({tag, "_rgb"}, {8'd0, red, green, blue}, 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; zoom_in = 0; zoom_out = 0; pan = 0; param_next = 0;
    req_ready = 0; resp_valid = 0; resp_iter = 0; sx = 0; sy = 0;
    m_cx = 0; m_cy = 0; m_zoom = 0;
    tick(); tick();
    chk_outputs_zero("reset");
    rst = 1'b0;

    // frame 1: default view, quantiser boundaries on pixels 0..3
    serve_frame(0, 1);
    repeat (5) tick();
    chk("frame_done_count1", 32'(fd_cnt), 32'd1);
    chk("done_hold", 32'(req_valid), 32'd0);
    chk("scoreboard_empty1", 32'(exp_q.size()), 32'd0);

    // three zoom steps, each restarting; then a full frame at step STEP0>>3
    for (int i = 0; i < 3; i++) begin
      zoom_in = 1'b1; tick(); zoom_in = 1'b0; tick();
      m_zoom++;
    end
    serve_frame(0, 0);
    repeat (5) tick();
    chk("frame_done_count2", 32'(fd_cnt), 32'd2);

    // saturated zoom and zoom_in+zoom_out must not restart
    zoom_in = 1'b1; tick(); zoom_in = 1'b0;
    repeat (5) tick();
    chk("zoom_sat_norestart", 32'(req_valid), 32'd0);
    zoom_in = 1'b1; zoom_out = 1'b1; tick(); zoom_in = 1'b0; zoom_out = 1'b0;
    repeat (5) tick();
    chk("zoom_both_norestart", 32'(req_valid), 32'd0);

    // param_next restart, then pan right while waiting on pixel 5
    param_next = 1'b1; tick(); param_next = 1'b0;
    chk("core_c_change_set", 32'(core_c_change), 32'd1);
    tick();
    chk("core_c_change_clr", 32'(core_c_change), 32'd0);
    for (int p = 0; p < 5; p++) serve_one(p, iter_for(p, 0), 1'b0);
    serve_one(5, 200, 1'b1);
    serve_frame(0, 0);
    repeat (5) tick();
    chk("frame_done_count3", 32'(fd_cnt), 32'd3);
    chk("scoreboard_empty3", 32'(exp_q.size()), 32'd0);

    // display read path
    sx = 16'd3; sy = 16'd1; tick();
    chk("rd_addr_3_1", 32'(rd_addr), 32'd11);
    tick();
    chk("rgb_3_1", {8'd0, red, green, blue}, {8'd0, 8'd238, 8'd238, 8'd238});
    sx = 16'd7; sy = 16'd3; tick();
    chk("rd_addr_7_3", 32'(rd_addr), 32'd31);
    tick();
    chk("rgb_7_3", {8'd0, red, green, blue}, {8'd0, 8'd170, 8'd170, 8'd170});
    sx = 16'(H); sy = 16'd1; tick(); tick();
    chk("rgb_x_oob", {8'd0, red, green, blue}, 32'd0);
    sx = 16'd0; sy = 16'(V); tick(); tick();
    chk("rgb_y_oob", {8'd0, red, green, blue}, 32'd0);

    // reset in the middle of a request
    param_next = 1'b1; tick(); param_next = 1'b0;
    n = 0;
    while (!req_valid && n < 50) begin tick(); n++; end
    chk("pre_reset_valid", 32'(req_valid), 32'd1);
    rst = 1'b1; tick();
    chk_outputs_zero("midrst");
    rst = 1'b0;
    m_cx = 0; m_cy = 0; m_zoom = 0;
    serve_frame(0, 0);
    repeat (5) tick();
    chk("frame_done_count4", 32'(fd_cnt), 32'd4);
    chk("scoreboard_empty4", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fractal_fb_ctrl.md
# fractal_fb_ctrl

Parametrised frame-buffer fill controller for the fractal HDMI pipeline. It scans every screen pixel and issues a fixed-point complex coordinate to the fractal iteration core over a valid/ready handshake. Each returned iteration count is quantised and written into the dual-port pixel BRAM. It also serves the display read side and supports zoom levels, panning and parameter-change redraws, restarting the scan whenever the view changes.

## Interface
- H_RES, 1280, active pixels per line
- V_RES, 720, active lines
- ADDR_W, 20, BRAM address width (≥ clog2(H_RES*V_RES))
- PIX_W, 4, stored bits per pixel
- ITER_W, 9, iteration-count width
- MAX_ITER, 256, core iteration limit (power of two)
- COORD_W, 32, signed Q(COORD_W-16).16 coordinate width
- ZOOM_LEVELS, 4, number of zoom steps (level 0 = widest)
- STEP0, 410, level-0 pixel pitch in Q.16 (≈0.00625)
- PAN_PIX, 64, pixels moved per pan pulse
- CX0, 0; CY0, 0, reset view centre in Q.16
- clk  in  1  pixel/system clock
- rst  in  1  synchronous, active-high reset
- zoom_in, zoom_out  in  1  single-cycle pulses (edge-detected upstream)
- pan  in  4  single-cycle pulses {up, down, left, right}
- param_next  in  1  pulse: advance core Julia constant
- core_c_change  out  1  registered copy of param_next
- req_valid  out  1  coordinate request valid
- req_ready  in  1  core accepts request
- req_x, req_y  out  COORD_W  signed request coordinates
- resp_valid  in  1  iteration result valid (single cycle)
- resp_iter  in  ITER_W  iteration count, 0..MAX_ITER
- wr_en  out  1  BRAM port-A write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  PIX_W  quantised pixel
- sx, sy  in  16  display scan position
- rd_addr  out  ADDR_W  BRAM port-B address
- rd_data  in  PIX_W  BRAM port-B data, one-cycle latency
- o_red, o_green, o_blue  out  8  pixel colour
- frame_done  out  1  single-cycle pulse: last pixel written

## Operation
- FSM: ISSUE → WAIT → WRITE → (next pixel) ISSUE; after pixel (H_RES-1, V_RES-1) → DONE, then hold until a view change.
- ISSUE: req_valid=1 with req_x/req_y stable until req_ready sampled high. WAIT: resp_valid captured. WRITE: wr_en=1 for one cycle, wr_addr = y*H_RES + x.
- resp_valid outside WAIT is ignored.
- Coordinates are incremental, with no divider. step = STEP0 >> zoom. Row start x = cx − (H_RES/2)*step. y starts at cy + (V_RES/2)*step and decrements by step per row, so the image is upright. x increments by step per pixel. All arithmetic is signed COORD_W, wrapping.
- Quantisation: code = min(resp_iter, MAX_ITER−1) >> (log2(MAX_ITER) − PIX_W). An iteration count of MAX_ITER saturates to all-ones.
- zoom_in raises the level, saturating at ZOOM_LEVELS−1. zoom_out lowers it, saturating at 0. zoom_in and zoom_out in the same cycle are ignored.
- A pan pulse shifts the centre by ±PAN_PIX*step. Multiple pan bits in one cycle apply together, with opposing bits cancelling.
- View change (any zoom/pan/param_next pulse that actually changes state):
  - A pending flag is set.
  - If in ISSUE with the request not yet accepted, req_valid drops and the scan restarts at (0,0) the next cycle.
  - If in WAIT, the response is consumed without a write, then the scan restarts.
  - In WRITE, the write completes, then the scan restarts.
  - In DONE, the scan restarts immediately.
- Saturated zoom pulses do not restart the scan.
- Read path: rd_addr = sy*H_RES + sx, registered. An in-range flag (sx<H_RES && sy<V_RES) is pipelined alongside. Out of range → black.

## Timing
- Reset values:
  - Outputs: req_valid, wr_en, frame_done, core_c_change = 0; rgb = 0; rd_addr = 0.
  - State: FSM = ISSUE at (0,0); zoom = 0; centre = (CX0, CY0).
- Reset mid-scan or mid-handshake aborts without a write.
- Request-to-write latency: one cycle after resp_valid, wr_en asserts. The next req_valid asserts the cycle after wr_en.
- frame_done pulses in the cycle after the final write.
- Display: sx/sy at cycle n → rgb valid at cycle n+2 (address register, BRAM, output register).

## Configuration
- FRACTAL_FB_PALETTE_EN defined: rgb comes from a 2^PIX_W-entry 24-bit colour LUT indexed by the pixel code.
- Undefined: greyscale output. The code is replicated to fill 8 bits (PIX_W=4: code*17), with o_red = o_green = o_blue.

## Structure
- Shared package fractal_pkg holds:
  - FSM state enum
  - Q.16 fraction-bit constant
  - Colour LUT
  - Quantisation function
- One sub-module, fractal_fb_view: holds zoom level, centre and step; outputs row-start coordinates and a view_changed pulse.

## Test plan
- Reset, H_RES=8, V_RES=4, core model with 2-cycle ready latency and resp_iter = x+y → 32 writes at addresses 0..31 in order; one frame_done pulse; FSM holds in DONE.
- resp_iter = 256, 255, 16, 15 → wr_data = 15, 15, 1, 0.
- Three zoom_in pulses, then a fourth → step = STEP0>>3 and the fourth causes no restart. zoom_in and zoom_out together → no change.
- Pan right during WAIT at pixel 5 → no write for pixel 5; next request is (0,0) with x = cx+PAN_PIX*step − (H_RES/2)*step.
- sx=3, sy=1 → rd_addr=11 one cycle later, rgb=gray(rd_data) two cycles later. sx=H_RES → black.
- rst asserted while req_valid is high → all outputs 0 the next cycle; scan resumes at (0,0) with default view.
